// File: rtl/lfsr_rr_sched.sv
// Shared 8-bit Galois LFSR byte source, round-robin granted to NUM_REQ requesters.
// Optional period self-check enabled by LFSR_RR_SCHED_PERIOD_CHK_EN.
module lfsr_rr_sched #(
  parameter int         NUM_REQ      = 4,
  parameter int         WARMUP_STEPS = 16,
  parameter logic [7:0] RESET_SEED   = 8'h01
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seed_valid,
  input  logic [7:0]         seed_data,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         rnd_data,
`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
  output logic               period_wrap,
  output logic               period_err,
`endif
  output logic               busy
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int PW1 = PW + 1;

  typedef enum logic {WARMUP, RUN} fsm_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n[7] = s[0];
    n[6] = s[7];
    n[5] = s[6] ^ s[0];
    n[4] = s[5] ^ s[0];
    n[3] = s[4];
    n[2] = s[3];
    n[1] = s[2];
    n[0] = s[1] ^ s[0];
    return n;
  endfunction

  fsm_e               fsm_q, fsm_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         rnd_q, rnd_d;

  logic [2*NUM_REQ-1:0] req_sh;
  logic [NUM_REQ-1:0]   rot;
  logic [PW1-1:0]       sum;
  logic [PW-1:0]        win;
  logic                 found;

  // Rotate req so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    req_sh = {req, req} >> ptr_q;
    rot    = req_sh[NUM_REQ-1:0];
    found  = 1'b0;
    win    = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[PW'(i)]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + PW1'(i);
        if (sum >= PW1'(NUM_REQ)) begin
          sum = sum - PW1'(NUM_REQ);
        end
        win = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    wcnt_d = wcnt_q;
    ptr_d  = ptr_q;
    gnt_d  = '0;
    rnd_d  = rnd_q;
    if (seed_valid) begin
      lfsr_d = (seed_data == 8'h00) ? 8'h01 : seed_data;
      wcnt_d = 8'(WARMUP_STEPS);
      fsm_d  = WARMUP;
    end else begin
      unique case (fsm_q)
        WARMUP: begin
          if (wcnt_q != 8'd0) begin
            lfsr_d = lfsr_step(lfsr_q);
            wcnt_d = wcnt_q - 8'd1;
          end else begin
            fsm_d = RUN;
          end
        end
        RUN: begin
          if (found) begin
            gnt_d  = NUM_REQ'(1) << win;
            rnd_d  = lfsr_q;
            lfsr_d = lfsr_step(lfsr_q);
            ptr_d  = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          end
        end
        default: fsm_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q  <= WARMUP;
      lfsr_q <= RESET_SEED;
      wcnt_q <= 8'(WARMUP_STEPS);
      ptr_q  <= '0;
      gnt_q  <= '0;
      rnd_q  <= 8'h00;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      wcnt_q <= wcnt_d;
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      rnd_q  <= rnd_d;
    end
  end

  assign gnt      = gnt_q;
  assign rnd_data = rnd_q;
  assign busy     = (fsm_q == WARMUP);

`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] start_q, start_d;
  logic [7:0] pnext;
  logic       wrap_q, wrap_d;
  logic       err_q, err_d;
  logic       adv;
  logic       start_cap;

  assign adv       = !seed_valid && (fsm_q == RUN) && found;
  assign start_cap = !seed_valid && (fsm_q == WARMUP) && (wcnt_q == 8'd0);

  // Start value is the state on entry to RUN; it must recur exactly every 255 advances.
  always_comb begin
    pcnt_d  = pcnt_q;
    start_d = start_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    pnext   = (pcnt_q == 8'd254) ? 8'd0 : pcnt_q + 8'd1;
    if (seed_valid) begin
      pcnt_d = '0;
      err_d  = 1'b0;
    end else if (start_cap) begin
      pcnt_d  = '0;
      start_d = lfsr_q;
    end else if (adv) begin
      pcnt_d = pnext;
      wrap_d = (pnext == 8'd0);
      if ((pnext == 8'd0) != (lfsr_d == start_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q  <= '0;
      start_q <= RESET_SEED;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      start_q <= start_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign period_wrap = wrap_q;
  assign period_err  = err_q;
`endif

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed table-driven bench for lfsr_rr_sched.
// Two instances: WARMUP_STEPS=0 (a) and WARMUP_STEPS=2 (b).
module tb_lfsr_rr_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       sv_a, sv_b;
  logic [7:0] sd_a, sd_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [7:0] rnd_a, rnd_b;
  logic       busy_a, busy_b;
`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
  logic       pw_a, pe_a, pw_b, pe_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  lfsr_rr_sched #(
    .NUM_REQ(4), .WARMUP_STEPS(0), .RESET_SEED(8'h01)
  ) u_a (
    .clock(clock), .reset(reset),
    .seed_valid(sv_a), .seed_data(sd_a),
    .req(req_a), .gnt(gnt_a), .rnd_data(rnd_a),
`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
    .period_wrap(pw_a), .period_err(pe_a),
`endif
    .busy(busy_a)
  );

  lfsr_rr_sched #(
    .NUM_REQ(4), .WARMUP_STEPS(2), .RESET_SEED(8'h01)
  ) u_b (
    .clock(clock), .reset(reset),
    .seed_valid(sv_b), .seed_data(sd_b),
    .req(req_b), .gnt(gnt_b), .rnd_data(rnd_b),
`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
    .period_wrap(pw_b), .period_err(pe_b),
`endif
    .busy(busy_b)
  );

  typedef struct {
    logic [3:0] req;
    logic       sv;
    logic [7:0] sd;
    logic [3:0] gnt;
    logic [7:0] rnd;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] r, input logic s,
                              input logic [7:0] d, input logic [3:0] g,
                              input logic [7:0] x, input logic b);
    vec_t v;
    v.req = r; v.sv = s; v.sd = d;
    v.gnt = g; v.rnd = x; v.busy = b;
    return v;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] s);
    logic [7:0] n;
    n = {s[0], s[7], s[6] ^ s[0], s[5] ^ s[0],
         s[4], s[3], s[2], s[1] ^ s[0]};
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_b;
    int         n;
    int         wraps;

    tbl.push_back(mk(4'b0001, 0, 8'h00, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(4'b0001, 0, 8'h00, 4'b0001, 8'h01, 0));
    tbl.push_back(mk(4'b0001, 0, 8'h00, 4'b0001, 8'hB1, 0));
    tbl.push_back(mk(4'b1111, 0, 8'h00, 4'b0010, 8'hE9, 0));
    tbl.push_back(mk(4'b1111, 0, 8'h00, 4'b0100, 8'hC5, 0));
    tbl.push_back(mk(4'b1111, 0, 8'h00, 4'b1000, 8'hD3, 0));
    tbl.push_back(mk(4'b1111, 0, 8'h00, 4'b0001, 8'hD8, 0));
    tbl.push_back(mk(4'b1111, 0, 8'h00, 4'b0010, 8'h6C, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(4'b0000, 0, 8'h00, 4'b0000, 8'h6C, 0));
    tbl.push_back(mk(4'b0100, 0, 8'h00, 4'b0100, 8'h36, 0));
    tbl.push_back(mk(4'b0010, 1, 8'h00, 4'b0000, 8'h36, 1));
    tbl.push_back(mk(4'b0010, 0, 8'h00, 4'b0000, 8'h36, 0));
    tbl.push_back(mk(4'b0010, 0, 8'h00, 4'b0010, 8'h01, 0));
    tbl.push_back(mk(4'b1000, 0, 8'h00, 4'b1000, 8'hB1, 0));
    tbl.push_back(mk(4'b0101, 0, 8'h00, 4'b0001, 8'hE9, 0));
    tbl.push_back(mk(4'b0101, 0, 8'h00, 4'b0100, 8'hC5, 0));

    // Reset held with a competing seed load on a.
    reset = 1'b1;
    sv_a = 1'b1; sd_a = 8'h55; req_a = 4'b0001;
    sv_b = 1'b0; sd_b = 8'h00; req_b = 4'b0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_rnd_a", 32'(rnd_a), 0);
    chk("rst_busy_a", 32'(busy_a), 1);
    chk("rst_gnt_b", 32'(gnt_b), 0);
    chk("rst_rnd_b", 32'(rnd_b), 0);
    chk("rst_busy_b", 32'(busy_b), 1);
    reset = 1'b0;
    sv_a = 1'b0; sd_a = 8'h00;

    foreach (tbl[i]) begin
      req_a = tbl[i].req;
      sv_a  = tbl[i].sv;
      sd_a  = tbl[i].sd;
      @(negedge clock);
      chk($sformatf("v%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_rnd", i), 32'(rnd_a), 32'(tbl[i].rnd));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
    end
    req_a = 4'b0000; sv_a = 1'b0;

    // b sat idle in RUN with state E9 after its 2-step warm-up.
    req_b = 4'b0010;
    @(negedge clock);
    chk("b_g1_gnt", 32'(gnt_b), 32'h2);
    chk("b_g1_rnd", 32'(rnd_b), 32'hE9);

    // Seed load collides with a pending request.
    sv_b = 1'b1; sd_b = 8'h01;
    @(negedge clock);
    sv_b = 1'b0;
    chk("b_seed_gnt", 32'(gnt_b), 0);
    chk("b_seed_busy", 32'(busy_b), 1);
    chk("b_seed_rnd", 32'(rnd_b), 32'hE9);
    @(negedge clock);
    chk("b_wu1_busy", 32'(busy_b), 1);
    @(negedge clock);
    chk("b_wu2_busy", 32'(busy_b), 1);
    @(negedge clock);
    chk("b_wu3_busy", 32'(busy_b), 0);
    chk("b_wu3_gnt", 32'(gnt_b), 0);

    n = 0;
    while (gnt_b == 4'b0000 && n < 8) begin
      @(negedge clock);
      n++;
    end
    chk("b_grant_lat", 32'(n), 1);
    chk("b_first_gnt", 32'(gnt_b), 32'h2);
    chk("b_first_rnd", 32'(rnd_b), 32'hE9);

    // Continuous grants across one full period.
    exp_b = 8'hE9;
    wraps = 0;
    for (int i = 2; i <= 256; i++) begin
      exp_b = step(exp_b);
      @(negedge clock);
      chk($sformatf("p%0d_gnt", i), 32'(gnt_b), 32'h2);
      chk($sformatf("p%0d_rnd", i), 32'(rnd_b), 32'(exp_b));
`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
      if (pw_b) wraps++;
      chk($sformatf("p%0d_err", i), 32'(pe_b), 0);
`endif
    end
    chk("byte256", 32'(rnd_b), 32'hE9);
`ifdef LFSR_RR_SCHED_PERIOD_CHK_EN
    chk("wrap_cnt", 32'(wraps), 1);
`endif
    req_b = 4'b0000;
    @(negedge clock);
    chk("b_idle_gnt", 32'(gnt_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_sched.md
Name: lfsr_rr_sched

Overview:
- Shared pseudo-random byte source for up to NUM_REQ requesters.
- Holds one 8-bit Galois LFSR using polynomial x^8+x^6+x^5+x+1.
- Sequences seeding and warm-up, then grants one random byte per cycle to requesters in round-robin order.
- Sits between the random-consuming blocks (scramblers, test-pattern gens) and removes the need for per-block LFSR instances.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WARMUP_STEPS, 16, LFSR advances after each seed load before grants begin; 0 to 255.
- RESET_SEED, 8'h01, LFSR state loaded at reset; must be nonzero.

Ports:
- clock  input  1  sole clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- seed_valid  input  1  load seed_data this cycle.
- seed_data  input  8  new LFSR seed.
- req  input  NUM_REQ  per-requester request level.
- gnt  output  NUM_REQ  one-hot grant pulse; registered.
- rnd_data  output  8  random byte; valid in the cycle gnt is nonzero.
- busy  output  1  high while in WARMUP.

Behaviour:
- LFSR step, s to s': s'[7]=s[0], s'[6]=s[7], s'[5]=s[6]^s[0], s'[4]=s[5]^s[0], s'[3]=s[4], s'[2]=s[3], s'[1]=s[2], s'[0]=s[1]^s[0].
- The sequence is 0x01, 0xB1, 0xE9, ... with period 255.
- FSM states are WARMUP and RUN.
- Reset:
  - state=RESET_SEED, wcnt=WARMUP_STEPS, fsm=WARMUP.
  - gnt=0, rnd_data=0, busy=1, rr pointer=0.
- WARMUP:
  - Each cycle with wcnt!=0: advance the LFSR and decrement wcnt.
  - When wcnt==0: go to RUN, busy=0 the next cycle.
  - WARMUP_STEPS=0 gives exactly one WARMUP cycle with no advance.
  - req is ignored and gnt=0.
- RUN arbitration, on each edge with req!=0:
  - Pick the first set bit searching from index ptr upward, wrapping modulo NUM_REQ.
  - Register gnt = one-hot of the winner and rnd_data = current state.
  - Advance the LFSR and set ptr = winner+1 mod NUM_REQ.
- Grant timing:
  - gnt is high exactly one cycle, the cycle after req is sampled.
  - A requester holding req gets back-to-back grants only when no other req is pending.
  - Throughput is one byte per cycle.
- RUN with req==0: gnt=0, rnd_data holds its last value, LFSR does not advance.
- seed_valid, in any state:
  - state = seed_data, or 8'h01 if seed_data==0 (lock-up guard).
  - wcnt=WARMUP_STEPS, fsm=WARMUP, gnt=0 next cycle, busy=1.
  - seed_valid takes priority over a simultaneous grant: no grant is issued that cycle and the LFSR does not step.
  - ptr is preserved.
- reset overrides seed_valid.
- Every consumed byte is unique within any 255 consecutive grants.

Optional Feature:
- Macro: LFSR_RR_SCHED_PERIOD_CHK_EN.
- When defined, add:
  - Output period_wrap (1 bit): one-cycle pulse when 255 RUN-mode advances since the last seed/reset have completed, counted modulo 255.
  - Output period_err (1 bit, sticky until reset or seed_valid): sets if the state equals the post-warm-up start value at any count other than 0 mod 255, or differs from it at the count-255 boundary.
- When undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset, WARMUP_STEPS=0, req=4'b0001 held → busy deasserts after 1 cycle; gnt=0001 on consecutive cycles with rnd_data 0x01, 0xB1, 0xE9.
- Fairness, req=4'b1111 held in RUN, ptr=0 → gnt order 0001, 0010, 0100, 1000, 0001, one per cycle, with successive LFSR values.
- seed_valid with seed_data=0x00, WARMUP_STEPS=0 → loads 0x01; first grant returns 0x01.
- seed_valid asserted in the same cycle as req=0010 during RUN → no grant next cycle, busy=1; with WARMUP_STEPS=2 the first subsequent rnd_data equals the seed stepped twice (seed 0x01 gives 0xE9).
- req=0 for 10 cycles in RUN, then req=0100 → rnd_data equals the value that followed the last grant, proving no advance while idle.
- With LFSR_RR_SCHED_PERIOD_CHK_EN: 255 continuous grants → period_wrap pulses once, period_err stays 0; byte 256 equals byte 1.
